// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - sequencer driving a 4-bit shift register through load/shift/done phases
module shift_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       load,
  input  logic       dir,
  input  logic [1:0] mode,
  input  logic [1:0] amt,
  input  logic [3:0] operand,
  input  logic [3:0] q,
  output logic [1:0] c,
  output logic [3:0] data_in,
  output logic       carry_msb,
  output logic       carry_lsb,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] C_HOLD  = 2'b00;
  localparam logic [1:0] C_RIGHT = 2'b01;
  localparam logic [1:0] C_LEFT  = 2'b10;
  localparam logic [1:0] C_LOAD  = 2'b11;

  localparam logic [1:0] M_ROTATE = 2'b01;
  localparam logic [1:0] M_ARITH  = 2'b10;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       dir_r;
  logic [1:0] mode_r;
  logic [3:0] operand_r;
  logic       accept;

  // A command is only taken while idle; start in any other state is dropped.
  assign accept = (state == S_IDLE) && start;

  // State and remaining-shift counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Command fields are frozen at acceptance so later input changes are harmless.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dir_r     <= 1'b0;
      mode_r    <= 2'b00;
      operand_r <= 4'b0000;
    end else if (accept) begin
      dir_r     <= dir;
      mode_r    <= mode;
      operand_r <= operand;
    end
  end

  // Next state; the counter is seeded with amt and LOAD uses it to pick SHIFT or DONE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_nx = amt;
          if (load)              state_nx = S_LOAD;
          else if (amt != 2'd0)  state_nx = S_SHIFT;
          else                   state_nx = S_DONE;
        end
      end
      S_LOAD: begin
        state_nx = (cnt != 2'd0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        cnt_nx = cnt - 2'd1;
        if (cnt <= 2'd1) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  // Moore decode of the shift-register controls; serial bits come from the fed-back q.
  always_comb begin
    c         = C_HOLD;
    busy      = 1'b0;
    done      = 1'b0;
    carry_msb = 1'b0;
    carry_lsb = 1'b0;
    case (state)
      S_LOAD: begin
        c    = C_LOAD;
        busy = 1'b1;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (dir_r) begin
          c         = C_LEFT;
          // Arithmetic left is identical to logical left.
          carry_lsb = (mode_r == M_ROTATE) ? q[3] : 1'b0;
        end else begin
          c = C_RIGHT;
          case (mode_r)
            M_ROTATE: carry_msb = q[0];
            M_ARITH:  carry_msb = q[3];
            default:  carry_msb = 1'b0;
          endcase
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        c = C_HOLD;
      end
    endcase
  end

  assign data_in = operand_r;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - scoreboard bench for shift_seq with a behavioural 4-bit shift register
module tb_shift_seq;

  logic       clk;
  logic       clr;
  logic       start;
  logic       load;
  logic       dir;
  logic [1:0] mode;
  logic [1:0] amt;
  logic [3:0] operand;
  logic [1:0] c;
  logic [3:0] data_in;
  logic       carry_msb;
  logic       carry_lsb;
  logic       busy;
  logic       done;

  logic [3:0] sr = 4'b0000;
  logic       pre_en = 1'b0;
  logic [3:0] pre_val = 4'b0000;

  typedef struct {
    int lat;
    int bsy;
    int trace;
    int qf;
    int din;
    int cm;
    int cl;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n = 0, bc = 0, tr = 0, cmc = 0, clc = 0, bad = 0, idle_bad = 0;

  shift_seq u_dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .load      (load),
    .dir       (dir),
    .mode      (mode),
    .amt       (amt),
    .operand   (operand),
    .q         (sr),
    .c         (c),
    .data_in   (data_in),
    .carry_msb (carry_msb),
    .carry_lsb (carry_lsb),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream shift register obeying c.
  always @(posedge clk) begin
    if (pre_en) sr <= pre_val;
    else begin
      case (c)
        2'b01: sr <= {carry_msb, sr[3:1]};
        2'b10: sr <= {sr[2:0], carry_lsb};
        2'b11: sr <= data_in;
        default: sr <= sr;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: accumulates one operation's trace and compares it when done appears.
  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      n = 0; bc = 0; tr = 0; cmc = 0; clc = 0; bad = 0;
    end else if (busy || done) begin
      n++;
      tr = (tr << 2) | int'(c);
      if (busy) bc++;
      if (c == 2'b01 && carry_msb) cmc++;
      if (c == 2'b10 && carry_lsb) clc++;
      if ((c != 2'b01 && carry_msb) || (c != 2'b10 && carry_lsb)) bad++;
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("latency", n, e.lat);
          chk("busy_cycles", bc, e.bsy);
          chk("c_trace", tr, e.trace);
          chk("final_q", int'(sr), e.qf);
          chk("data_in", int'(data_in), e.din);
          chk("carry_msb_cycles", cmc, e.cm);
          chk("carry_lsb_cycles", clc, e.cl);
          chk("stray_carry", bad, 0);
        end
        n = 0; bc = 0; tr = 0; cmc = 0; clc = 0; bad = 0;
      end
    end else if (c != 2'b00 || carry_msb || carry_lsb) begin
      idle_bad++;
    end
  end

  task automatic preset(input logic [3:0] v);
    @(negedge clk); pre_en = 1'b1; pre_val = v;
    @(negedge clk); pre_en = 1'b0;
  endtask

  // Issue one command; inputs are scrambled right after acceptance.
  task automatic issue(input logic l, input logic d, input logic [1:0] m, input logic [1:0] a,
                       input logic [3:0] op, input bit expect_done, input exp_t e);
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    load = l; dir = d; mode = m; amt = a; operand = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; load = ~l; dir = ~d; mode = ~m; amt = ~a; operand = ~op;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle_timeout", int'(ok), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_c"}, int'(c), 0);
    chk({tag, "_data_in"}, int'(data_in), 0);
    chk({tag, "_carry_msb"}, int'(carry_msb), 0);
    chk({tag, "_carry_lsb"}, int'(carry_lsb), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    exp_t e;
    clr = 1'b1; start = 1'b1; load = 1'b1; dir = 1'b0; mode = 2'b00; amt = 2'd3; operand = 4'hF;
    #1;
    chk_reset_outputs("reset_t0");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    @(negedge clk);
    clr = 1'b0; start = 1'b0;

    // Logical right by 2 after load.
    e = '{lat:4, bsy:3, trace:'hD4, qf:4'b0011, din:4'b1100, cm:0, cl:0};
    issue(1'b1, 1'b0, 2'b00, 2'd2, 4'b1100, 1'b1, e);
    wait_idle();

    // Rotate left by 1 on existing q.
    preset(4'b1001);
    e = '{lat:2, bsy:1, trace:'h08, qf:4'b0011, din:4'b0000, cm:0, cl:1};
    issue(1'b0, 1'b1, 2'b01, 2'd1, 4'b0000, 1'b1, e);
    wait_idle();

    // Arithmetic right by 3 after load.
    e = '{lat:5, bsy:4, trace:'h354, qf:4'b1111, din:4'b1000, cm:3, cl:0};
    issue(1'b1, 1'b0, 2'b10, 2'd3, 4'b1000, 1'b1, e);
    wait_idle();

    // Rotate right by 1.
    e = '{lat:3, bsy:2, trace:'h34, qf:4'b1000, din:4'b0001, cm:1, cl:0};
    issue(1'b1, 1'b0, 2'b01, 2'd1, 4'b0001, 1'b1, e);
    wait_idle();

    // Arithmetic left by 2 behaves as logical left.
    e = '{lat:4, bsy:3, trace:'hE8, qf:4'b1100, din:4'b1011, cm:0, cl:0};
    issue(1'b1, 1'b1, 2'b10, 2'd2, 4'b1011, 1'b1, e);
    wait_idle();

    // Mode 11 right behaves as logical.
    e = '{lat:3, bsy:2, trace:'h34, qf:4'b0111, din:4'b1111, cm:0, cl:0};
    issue(1'b1, 1'b0, 2'b11, 2'd1, 4'b1111, 1'b1, e);
    wait_idle();

    // load=0, amt=0: done immediately, no busy.
    preset(4'b0101);
    e = '{lat:1, bsy:0, trace:0, qf:4'b0101, din:4'b1001, cm:0, cl:0};
    issue(1'b0, 1'b0, 2'b00, 2'd0, 4'b1001, 1'b1, e);
    wait_idle();

    // Start pulses during SHIFT and DONE of another command are ignored.
    e = '{lat:4, bsy:3, trace:'hE8, qf:4'b1000, din:4'b0110, cm:0, cl:0};
    sb.push_back(e);
    @(negedge clk); load = 1'b1; dir = 1'b1; mode = 2'b00; amt = 2'd2; operand = 4'b0110; start = 1'b1;
    @(negedge clk); start = 1'b0; load = 1'b0; amt = 2'd0; dir = 1'b0; operand = 4'b0001;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset during the second SHIFT cycle aborts with no done.
    issue(1'b1, 1'b0, 2'b00, 2'd3, 4'b1010, 1'b0, e);
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    #1 clr = 1'b1;
    #1;
    chk_reset_outputs("abort");
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_held_busy", int'(busy), 0);
    chk("abort_held_c", int'(c), 0);
    @(negedge clk);
    clr = 1'b0; start = 1'b0;

    // First start after release is accepted at the next edge.
    preset(4'b1111);
    e = '{lat:3, bsy:2, trace:'h38, qf:4'b0110, din:4'b0011, cm:0, cl:0};
    sb.push_back(e);
    @(negedge clk); clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b1; load = 1'b1; dir = 1'b1; mode = 2'b01; amt = 2'd1; operand = 4'b0011;
    @(posedge clk); #1;
    chk("accept_after_release", int'(busy), 1);
    @(negedge clk); start = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("idle_outputs", idle_bad, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
